// File: rtl/noc_config_scheduler.sv
// noc_config_scheduler
// Queues 11-bit route-configuration words for the four processor ports of a 2x2 mesh and
// launches them round-robin, limited by a global in-flight cap. Each launch drives the
// processor's configure output for a fixed hold window, then waits for the processor's ready
// line to drop and rise again (completion), aborting with a sticky error on timeout.
//
// Ports:
//   clock_i                    system clock, rising edge
//   reset_i                    synchronous, active-high reset
//   req_valid_i / req_ready_o  host request handshake (ready = source FIFO not full)
//   req_src_i                  target processor 0..3
//   req_word_i                 configuration word (all-zero words are accepted and dropped)
//   processor_ready_signals_i  per-processor ready from the mesh
//   p0..p3_configure_o         registered configure words to the mesh
//   busy_o                     bit n set while processor n is not idle
//   inflight_count_o           number of busy processors
//   timeout_err_o              sticky per-processor timeout flags
module noc_config_scheduler #(
  parameter int unsigned FifoDepth   = 4,
  parameter int unsigned HoldCycles  = 4,
  parameter int unsigned MaxInflight = 2,
  parameter int unsigned Timeout     = 256
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_src_i,
  input  logic [10:0] req_word_i,
  input  logic [3:0]  processor_ready_signals_i,
  output logic [10:0] p0_configure_o,
  output logic [10:0] p1_configure_o,
  output logic [10:0] p2_configure_o,
  output logic [10:0] p3_configure_o,
  output logic [3:0]  busy_o,
  output logic [2:0]  inflight_count_o,
  output logic [3:0]  timeout_err_o
);

  localparam int unsigned PtrW  = $clog2(FifoDepth);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned HoldW = $clog2(HoldCycles + 1);
  localparam int unsigned ToW   = $clog2(Timeout);
  localparam logic [2:0]  MaxInfl = 3'(MaxInflight);

  typedef enum logic [1:0] {StIdle, StDrive, StAck, StDone} state_e;

  // State
  state_e            state_q [4];
  state_e            state_d [4];
  logic [HoldW-1:0]  hold_q  [4];
  logic [HoldW-1:0]  hold_d  [4];
  logic [ToW-1:0]    to_q    [4];
  logic [ToW-1:0]    to_d    [4];
  logic [10:0]       cfg_q   [4];
  logic [10:0]       cfg_d   [4];
  logic [3:0]        err_q, err_d;
  logic [1:0]        rr_q, rr_d;

  logic [10:0]       mem_q   [4][FifoDepth];
  logic [PtrW-1:0]   wptr_q  [4];
  logic [PtrW-1:0]   wptr_d  [4];
  logic [PtrW-1:0]   rptr_q  [4];
  logic [PtrW-1:0]   rptr_d  [4];
  logic [CntW-1:0]   cnt_q   [4];
  logic [CntW-1:0]   cnt_d   [4];

  // Combinational helpers
  logic [3:0] fifo_empty, fifo_full, eligible, push_vec, pop_vec;
  logic [2:0] inflight;
  logic       push;
  logic       grant_vld;
  logic [1:0] grant_idx, scan_idx;

  always_comb begin
    inflight = '0;
    for (int n = 0; n < 4; n++) begin
      fifo_empty[n] = (cnt_q[n] == '0);
      fifo_full[n]  = (cnt_q[n] == CntW'(FifoDepth));
      inflight      = inflight + {2'b00, (state_q[n] != StIdle)};
    end
  end

  // Full is registered, so a same-cycle pop never makes room for a same-cycle push.
  assign req_ready_o = ~fifo_full[req_src_i];
  assign push        = req_valid_i & req_ready_o & (|req_word_i);

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      eligible[n] = ~fifo_empty[n] & (state_q[n] == StIdle) & processor_ready_signals_i[n] &
                    (inflight < MaxInfl);
    end
  end

  // Round-robin scan starting at rr_q; first eligible source wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_q;
    scan_idx  = rr_q;
    for (int i = 0; i < 4; i++) begin
      scan_idx = rr_q + 2'(i);
      if (!grant_vld && eligible[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  assign rr_d = grant_vld ? grant_idx + 2'd1 : rr_q;

  // FIFO pointer/count next state
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      push_vec[n] = push && (req_src_i == 2'(n));
      pop_vec[n]  = grant_vld && (grant_idx == 2'(n));
      wptr_d[n]   = wptr_q[n] + PtrW'(push_vec[n]);
      rptr_d[n]   = rptr_q[n] + PtrW'(pop_vec[n]);
      cnt_d[n]    = cnt_q[n] + CntW'(push_vec[n]) - CntW'(pop_vec[n]);
    end
  end

  // Per-processor FSM next state
  always_comb begin
    err_d = err_q;
    for (int n = 0; n < 4; n++) begin
      state_d[n] = state_q[n];
      hold_d[n]  = hold_q[n];
      to_d[n]    = to_q[n];
      cfg_d[n]   = cfg_q[n];
      unique case (state_q[n])
        StIdle: begin
          if (pop_vec[n]) begin
            state_d[n] = StDrive;
            cfg_d[n]   = mem_q[n][rptr_q[n]];
            hold_d[n]  = HoldW'(HoldCycles - 1);
          end
        end
        StDrive: begin
          if (hold_q[n] == '0) begin
            state_d[n] = StAck;
            cfg_d[n]   = '0;
            to_d[n]    = '0;
          end else begin
            hold_d[n] = hold_q[n] - HoldW'(1);
          end
        end
        StAck, StDone: begin
          // Completion takes priority over a coincident timeout.
          if (state_q[n] == StDone && processor_ready_signals_i[n]) begin
            state_d[n] = StIdle;
          end else if (to_q[n] == ToW'(Timeout - 1)) begin
            state_d[n] = StIdle;
            err_d[n]   = 1'b1;
          end else begin
            to_d[n] = to_q[n] + ToW'(1);
            if (state_q[n] == StAck && !processor_ready_signals_i[n]) begin
              state_d[n] = StDone;
            end
          end
        end
        default: state_d[n] = StIdle;
      endcase
    end
  end

  // State register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int n = 0; n < 4; n++) begin
        state_q[n] <= StIdle;
        hold_q[n]  <= '0;
        to_q[n]    <= '0;
        cfg_q[n]   <= '0;
        wptr_q[n]  <= '0;
        rptr_q[n]  <= '0;
        cnt_q[n]   <= '0;
      end
      err_q <= '0;
      rr_q  <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        state_q[n] <= state_d[n];
        hold_q[n]  <= hold_d[n];
        to_q[n]    <= to_d[n];
        cfg_q[n]   <= cfg_d[n];
        wptr_q[n]  <= wptr_d[n];
        rptr_q[n]  <= rptr_d[n];
        cnt_q[n]   <= cnt_d[n];
      end
      err_q <= err_d;
      rr_q  <= rr_d;
    end
  end

  // FIFO storage needs no reset; pointers and counts define validity.
  always_ff @(posedge clock_i) begin
    if (push) begin
      mem_q[req_src_i][wptr_q[req_src_i]] <= req_word_i;
    end
  end

  // Outputs
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      busy_o[n] = (state_q[n] != StIdle);
    end
    inflight_count_o = inflight;
    timeout_err_o    = err_q;
    p0_configure_o   = cfg_q[0];
    p1_configure_o   = cfg_q[1];
    p2_configure_o   = cfg_q[2];
    p3_configure_o   = cfg_q[3];
  end

endmodule

// File: tb/tb_noc_config_scheduler.sv
module tb_noc_config_scheduler;

  localparam int Depth   = 4;
  localparam int Hold    = 4;
  localparam int MaxInfl = 2;
  localparam int Tmo     = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_src;
  logic [10:0] req_word;
  logic [3:0]  rdy;
  logic [10:0] p0, p1, p2, p3;
  logic [3:0]  busy;
  logic [2:0]  infl;
  logic [3:0]  terr;

  always #5 clk = ~clk;

  noc_config_scheduler #(
    .FifoDepth  (Depth),
    .HoldCycles (Hold),
    .MaxInflight(MaxInfl),
    .Timeout    (Tmo)
  ) dut (
    .clock_i                  (clk),
    .reset_i                  (rst),
    .req_valid_i              (req_valid),
    .req_ready_o              (req_ready),
    .req_src_i                (req_src),
    .req_word_i               (req_word),
    .processor_ready_signals_i(rdy),
    .p0_configure_o           (p0),
    .p1_configure_o           (p1),
    .p2_configure_o           (p2),
    .p3_configure_o           (p3),
    .busy_o                   (busy),
    .inflight_count_o         (infl),
    .timeout_err_o            (terr)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: queues per source, launch timestamps per processor.
  logic [10:0] mq [4][$];
  bit          act      [4];
  int          launch   [4];
  bit          low_seen [4];
  logic [10:0] m_cfg    [4];
  bit          m_err    [4];
  int          rr  = 0;
  int          cyc = 0;

  typedef struct {
    int          src;
    logic [10:0] word;
    int          cyc;
  } launch_t;
  launch_t sb[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_step();
    int  nb;
    int  g;
    int  k;
    int  e;
    bit  full_now [4];
    cyc++;
    e = cyc;
    if (rst) begin
      for (int n = 0; n < 4; n++) begin
        mq[n].delete();
        act[n] = 0; m_cfg[n] = '0; m_err[n] = 0; low_seen[n] = 0;
      end
      rr = 0;
      return;
    end
    nb = 0;
    for (int n = 0; n < 4; n++) begin
      full_now[n] = (mq[n].size() >= Depth);
      if (act[n]) nb++;
    end
    g = -1;
    if (nb < MaxInfl) begin
      for (int i = 0; i < 4; i++) begin
        k = (rr + i) % 4;
        if (g < 0 && mq[k].size() != 0 && !act[k] && rdy[k]) g = k;
      end
    end
    for (int n = 0; n < 4; n++) begin
      if (act[n]) begin
        if (e < launch[n] + Hold) begin
          // word still on the configure output
        end else if (e == launch[n] + Hold) begin
          m_cfg[n] = '0;
        end else if (low_seen[n] && rdy[n]) begin
          act[n] = 0;
        end else if (e == launch[n] + Hold + Tmo) begin
          m_err[n] = 1;
          act[n]   = 0;
        end else if (!rdy[n]) begin
          low_seen[n] = 1;
        end
      end
    end
    if (g >= 0) begin
      m_cfg[g]    = mq[g].pop_front();
      act[g]      = 1;
      launch[g]   = e;
      low_seen[g] = 0;
      rr          = (g + 1) % 4;
      sb.push_back('{g, m_cfg[g], e});
    end
    if (req_valid && !full_now[req_src] && req_word != '0) mq[req_src].push_back(req_word);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: compare registered outputs on the falling edge; pop scoreboard on each launch.
  logic [10:0] prev [4] = '{default: '0};
  initial forever begin
    logic [10:0] dp [4];
    logic [3:0]  eb, ee;
    int          ni;
    launch_t     ent;
    @(negedge clk);
    dp[0] = p0; dp[1] = p1; dp[2] = p2; dp[3] = p3;
    ni = 0;
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("cfg%0d", n), 32'(dp[n]), 32'(m_cfg[n]));
      if (dp[n] != '0 && prev[n] == '0) begin
        if (sb.size() == 0) begin
          chk($sformatf("launch%0d_unexpected", n), 32'(dp[n]), 32'd0);
        end else begin
          ent = sb.pop_front();
          chk("launch_src", 32'(n), 32'(ent.src));
          chk("launch_word", 32'(dp[n]), 32'(ent.word));
          chk("launch_cycle", 32'(cyc), 32'(ent.cyc));
        end
      end
      prev[n] = dp[n];
      eb[n] = act[n];
      ee[n] = m_err[n];
      if (act[n]) ni++;
    end
    chk("busy", 32'(busy), 32'(eb));
    chk("inflight", 32'(infl), 32'(ni));
    chk("inflight_cap", 32'(infl <= 3'(MaxInfl)), 32'd1);
    chk("timeout_err", 32'(terr), 32'(ee));
    chk("req_ready", 32'(req_ready), 32'(mq[req_src].size() < Depth));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [10:0] w);
    @(posedge clk);
    #2;
    req_valid = v;
    req_src   = s;
    req_word  = w;
  endtask

  task automatic pulse_low(input logic [3:0] mask, input int lo, input int after);
    rdy = rdy & ~mask;
    step(lo);
    rdy = rdy | mask;
    step(after);
  endtask

  function automatic logic [10:0] rword();
    logic [10:0] w;
    w = 11'($urandom);
    if (w == '0) w = 11'h1;
    return w;
  endfunction

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_src = '0; req_word = '0; rdy = 4'hF;
    step(3);
    rst = 1'b0;
    step(2);

    // T1: two words, src2 then src3
    drive(1'b1, 2'd2, 11'b01000000011);
    drive(1'b1, 2'd3, 11'b01000000001);
    drive(1'b0, 2'd0, '0);
    step(6);
    pulse_low(4'hF, 2, 4);

    // T2: one word per source with in-flight cap
    for (int s = 0; s < 4; s++) drive(1'b1, 2'(s), rword());
    drive(1'b0, 2'd0, '0);
    step(8);
    repeat (3) pulse_low(4'hF, 2, 8);

    // T3: fill src1 while ready1 is low; fifth push must be refused
    rdy = 4'hD;
    for (int i = 0; i < 5; i++) drive(1'b1, 2'd1, rword());
    drive(1'b0, 2'd1, '0);
    step(5);
    rdy = 4'hF;
    step(8);
    repeat (6) pulse_low(4'hF, 2, 8);

    // T4: ready0 held high forever -> timeout, then next src0 word launches
    drive(1'b1, 2'd0, rword());
    drive(1'b1, 2'd0, rword());
    drive(1'b0, 2'd0, '0);
    step(2 * Tmo + 30);
    pulse_low(4'hF, 2, 8);

    // T5: reset during a src3 drive window
    drive(1'b1, 2'd3, rword());
    drive(1'b1, 2'd3, rword());
    drive(1'b0, 2'd3, '0);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(3);

    // T6: zero word dropped, then rr order after a src0 grant
    drive(1'b1, 2'd0, '0);
    drive(1'b0, 2'd0, '0);
    step(3);
    rdy = 4'h1;
    drive(1'b1, 2'd0, rword());
    for (int s = 1; s < 4; s++) drive(1'b1, 2'(s), rword());
    drive(1'b0, 2'd0, '0);
    rdy = 4'hF;
    step(6);
    repeat (4) pulse_low(4'hF, 2, 8);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #2;
      req_valid = 1'($urandom % 2);
      req_src   = 2'($urandom);
      req_word  = ($urandom % 8 == 0) ? 11'h0 : 11'($urandom);
      for (int b = 0; b < 4; b++) if ($urandom % 4 == 0) rdy[b] = ~rdy[b];
      rst = ($urandom % 500 == 0);
    end
    rst = 1'b0;
    req_valid = 1'b0;
    rdy = 4'hF;

    // Drain everything still queued
    repeat (40) pulse_low(4'hF, 1, Hold + 3);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    for (int n = 0; n < 4; n++) chk($sformatf("fifo%0d_empty", n), 32'(mq[n].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
